ctrl_sequencer: RTL and testbench

Sequential fetch/decode/execute controller for the 8-bit processor. It drives the program counter into `inst_reg`, latches the 16-bit instruction, and sequences `registers` and `alu` to execute LOAD, ADD, SUB and JMP. It replaces the hand-timed sequencing previously done by bench code, and sits between the instruction store, the register file and the ALU.

---
 rtl/cpu_pkg.sv | 68 ++++++
 rtl/ctrl_sequencer_if.sv | 44 ++++
 rtl/inst_decode.sv | 28 ++
 rtl/ctrl_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 8-bit processor control path:
//     - instruction class opcodes (ir[15:12])
//     - ALU operation codes driven on alu_opcode
//     - sequencer FSM state encoding
//     - decoded-instruction record produced by inst_decode
//   Helper functions map a raw class nibble to a symbolic class and a
//   symbolic class to the ALU operation it needs.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Instruction class field values.
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  // ALU operation codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // Sequencer states. FETCH is the reset state and is pinned to zero.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_READ_A = 3'd2,
    S_READ_B = 3'd3,
    S_EXEC   = 3'd4,
    S_WRITE  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Symbolic instruction class; every unlisted opcode collapses to NOP.
  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_LOAD = 3'd1,
    CLS_ADD  = 3'd2,
    CLS_SUB  = 3'd3,
    CLS_JMP  = 3'd4
  } inst_class_t;

  // Fields of the latched instruction.
  typedef struct packed {
    inst_class_t cls;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [7:0]  imm;   // LOAD immediate or JMP target
  } decoded_t;

  function automatic inst_class_t classify(input logic [3:0] op);
    inst_class_t cls;
    case (op)
      OP_LOAD: cls = CLS_LOAD;
      OP_ADD:  cls = CLS_ADD;
      OP_SUB:  cls = CLS_SUB;
      OP_JMP:  cls = CLS_JMP;
      default: cls = CLS_NOP;
    endcase
    return cls;
  endfunction

  function automatic logic [2:0] alu_code(input inst_class_t cls);
    return (cls == CLS_SUB) ? ALU_SUB : ALU_ADD;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer_if
//   Bundle of every signal between the sequencer and its surroundings
//   (instruction store, register file, ALU).
//   master : the sequencer - drives pc/ir_en, register strobes, ALU operands,
//            halted; receives ir_data, reg_rdata, alu_result.
//   slave  : the datapath side - the exact reverse.
//   Timing contract seen by the slave:
//     ir_data    combinational from pc while ir_en is high
//     reg_rdata  combinational from reg_addr while reg_rd is high
//     alu_result combinational from alu_opcode/alu_a/alu_b
// -----------------------------------------------------------------------------
interface ctrl_sequencer_if;

  logic [7:0]  pc;
  logic        ir_en;
  logic [15:0] ir_data;

  logic [1:0]  reg_addr;
  logic        reg_rd;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;

  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;

  logic        halted;

  modport master (
    output pc, ir_en, reg_addr, reg_rd, reg_wr, reg_wdata,
           alu_opcode, alu_a, alu_b, halted,
    input  ir_data, reg_rdata, alu_result
  );

  modport slave (
    input  pc, ir_en, reg_addr, reg_rd, reg_wr, reg_wdata,
           alu_opcode, alu_a, alu_b, halted,
    output ir_data, reg_rdata, alu_result
  );

endinterface

// File: rtl/inst_decode.sv
// -----------------------------------------------------------------------------
// inst_decode
//   Purely combinational field extraction from the latched instruction.
//   Ports:
//     ir   in  16  latched instruction word
//     dec  out     decoded_t: class, rd (ir[9:8]), rs1 (ir[5:4]),
//                  rs2 (ir[1:0]), immediate/target (ir[7:0])
// -----------------------------------------------------------------------------
module inst_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output decoded_t    dec
);

  // ir[11:10] has no meaning in this ISA; reduced here so it is visibly consumed.
  logic unused_bits;
  assign unused_bits = ^ir[11:10];

  always_comb begin
    dec.cls = classify(ir[15:12]);
    dec.rd  = ir[9:8];
    dec.rs1 = ir[5:4];
    dec.rs2 = ir[1:0];
    dec.imm = ir[7:0];
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer
//   Fetch/decode/execute controller for the 8-bit processor. Walks the
//   program counter through the instruction store, latches each instruction
//   and sequences register reads, the ALU and the register write-back for
//   LOAD, ADD, SUB and JMP. Other classes behave as NOP. Execution stops in
//   HALT once the PC reaches PROG_LEN or beyond; only rst leaves HALT.
//
//   Parameters:
//     PROG_LEN  first PC value outside the program (halt address)
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   asynchronous, active-high reset
//     bus   master side of ctrl_sequencer_if (see that file for signals)
//
//   Cycles from one FETCH to the next: LOAD 3, ADD/SUB 6, JMP/NOP 2.
//   pc, alu_a, alu_b, alu_opcode and halted are registers. The strobes
//   (ir_en, reg_rd, reg_wr) and reg_addr/reg_wdata are decoded from the
//   registered state, so each strobe is high for exactly the one cycle
//   spent in its state and drops as soon as reset forces the state back.
// -----------------------------------------------------------------------------
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PROG_LEN = 11
)
(
  input logic              clk,
  input logic              rst,
  ctrl_sequencer_if.master bus
);

  // Nine bits so a PROG_LEN of 256 still compares correctly against the PC.
  localparam logic [8:0] PROG_END = 9'(PROG_LEN);

  state_t     state;
  logic [7:0] pc_q;
  logic [15:0] ir_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [2:0] alu_op_q;
  logic [7:0] result_q;
  logic       halted_q;

  decoded_t   dec;
  logic       at_end;

  inst_decode u_decode (
    .ir  (ir_q),
    .dec (dec)
  );

  assign at_end = ({1'b0, pc_q} >= PROG_END);

  // ---------------------------------------------------------------------------
  // State, PC and operand registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others and the order of
  // statements inside this block carries no meaning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= ALU_ADD;
      result_q <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (at_end) begin
            state    <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            ir_q  <= bus.ir_data;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (dec.cls)
            CLS_LOAD: state <= S_WRITE;
            CLS_ADD, CLS_SUB: begin
              // Set now so alu_result is already correct in EXEC; the code
              // then holds until the next arithmetic instruction.
              alu_op_q <= alu_code(dec.cls);
              state    <= S_READ_A;
            end
            CLS_JMP: begin
              pc_q  <= dec.imm;
              state <= S_FETCH;
            end
            default: begin
              pc_q  <= pc_q + 8'd1;
              state <= S_FETCH;
            end
          endcase
        end

        // Both operands are captured before WRITE, so rd == rs1/rs2 uses the
        // pre-write values with no extra handling.
        S_READ_A: begin
          alu_a_q <= bus.reg_rdata;
          state   <= S_READ_B;
        end

        S_READ_B: begin
          alu_b_q <= bus.reg_rdata;
          state   <= S_EXEC;
        end

        S_EXEC: begin
          result_q <= bus.alu_result;
          state    <= S_WRITE;
        end

        S_WRITE: begin
          pc_q  <= pc_q + 8'd1;
          state <= S_FETCH;
        end

        S_HALT: state <= S_HALT;

        // Unused encoding: park rather than run from an unknown point.
        default: begin
          state    <= S_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Strobes, address and write data decoded from the current state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output is given a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    bus.ir_en     = 1'b0;
    bus.reg_rd    = 1'b0;
    bus.reg_wr    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;

    case (state)
      // The state already sits in FETCH while rst is held, so the fetch
      // strobe is masked by rst to keep it low during reset.
      S_FETCH: bus.ir_en = ~rst & ~at_end;

      S_READ_A: begin
        bus.reg_rd   = 1'b1;
        bus.reg_addr = dec.rs1;
      end

      S_READ_B: begin
        bus.reg_rd   = 1'b1;
        bus.reg_addr = dec.rs2;
      end

      S_WRITE: begin
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = dec.rd;
        bus.reg_wdata = (dec.cls == CLS_LOAD) ? dec.imm : result_q;
      end

      default: ;
    endcase
  end

  assign bus.pc         = pc_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ctrl_sequencer
//   Self-checking bench for ctrl_sequencer. The bench plays instruction
//   store, register file and ALU, and holds an instruction-level model of
//   the program (architectural PC and registers, per-class cycle counts).
//   Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ctrl_sequencer;

  localparam int PROG_LEN = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_en = 1'b0;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [15:0] prog   [256];
  logic [7:0]  rf     [4];
  logic [7:0]  init_r [4];

  always #5 clk = ~clk;

  ctrl_sequencer_if bus ();

  ctrl_sequencer #(.PROG_LEN(PROG_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction store: a recognisable LOAD pattern outside ir_en windows.
  assign bus.ir_data    = bus.ir_en ? prog[bus.pc] : 16'h83FF;
  // Register file read port: junk value when not strobed.
  assign bus.reg_rdata  = bus.reg_rd ? rf[bus.reg_addr] : 8'hA5;
  // ALU: 000 add, 001 sub, anything else zero.
  assign bus.alu_result = (bus.alu_opcode == 3'b000) ? bus.alu_a + bus.alu_b :
                          (bus.alu_opcode == 3'b001) ? bus.alu_a - bus.alu_b : 8'h00;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 4; i++) rf[i] <= init_r[i];
    end else if (bus.reg_wr) begin
      rf[bus.reg_addr] <= bus.reg_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.pc, bus.ir_en, bus.reg_addr, bus.reg_rd, bus.reg_wr,
                bus.reg_wdata, bus.alu_opcode, bus.alu_a, bus.alu_b, bus.halted});
  endfunction

  task automatic fill_prog(input logic [15:0] w);
    for (int i = 0; i < 256; i++) prog[i] = w;
  endtask

  // Reset ends just after a rising edge; the next falling edge is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    load_en = 1'b1;
    #1 check("reset_outputs", out_vec(), 64'd0);
    @(posedge clk);
    #1 load_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_inst();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 4))
      0: w[15:12] = 4'b1000;
      1: w[15:12] = 4'b0000;
      2: w[15:12] = 4'b0001;
      3: begin
        w[15:12] = 4'b1111;
        w[7:0]   = 8'($urandom_range(0, 13));
      end
      default: begin
        w[15:12] = 4'($urandom_range(2, 14));
        if (w[15:12] == 4'b1000) w[15:12] = 4'b0101;
      end
    endcase
    return w;
  endfunction

  // Runs prog from reset, comparing each instruction's cycle window with the
  // architectural model, until halt or max_instr instructions.
  task automatic run_program(input string name, input int max_instr);
    logic [7:0]  m_pc, m_a, m_b, next_pc, src_a, src_b, exp_wd, wd;
    logic [7:0]  m_r [4];
    logic [2:0]  m_op;
    logic [15:0] ins;
    logic [1:0]  exp_wa, wa;
    logic [3:0]  rd_addrs;
    bit          exp_wr, arith;
    int          lat, n_rd, n_wr, n_fetch, n_both, wr_off;

    for (int i = 0; i < 4; i++) m_r[i] = init_r[i];
    m_pc = 8'd0;
    m_a  = 8'd0;
    m_b  = 8'd0;
    m_op = 3'b000;
    do_reset();

    for (int k = 0; k < max_instr; k++) begin
      if (m_pc >= 8'(PROG_LEN)) begin
        @(negedge clk);
        check($sformatf("%s halt_fetch pc=%0d", name, m_pc),
              64'({bus.ir_en, bus.reg_rd, bus.reg_wr, bus.pc}),
              64'({1'b0, 1'b0, 1'b0, m_pc}));
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check($sformatf("%s halted[%0d]", name, c),
                64'({bus.halted, bus.ir_en, bus.reg_rd, bus.reg_wr, bus.pc}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, m_pc}));
        end
        return;
      end

      // Architectural effect of the instruction at m_pc.
      ins     = prog[m_pc];
      next_pc = m_pc + 8'd1;
      exp_wr  = 1'b0;
      arith   = 1'b0;
      exp_wa  = ins[9:8];
      exp_wd  = 8'd0;
      src_a   = m_r[ins[5:4]];
      src_b   = m_r[ins[1:0]];
      lat     = 2;
      case (ins[15:12])
        4'b1000: begin lat = 3; exp_wr = 1'b1; exp_wd = ins[7:0]; end
        4'b0000: begin lat = 6; exp_wr = 1'b1; arith = 1'b1; exp_wd = src_a + src_b; end
        4'b0001: begin lat = 6; exp_wr = 1'b1; arith = 1'b1; exp_wd = src_a - src_b; end
        4'b1111: next_pc = ins[7:0];
        default: ;
      endcase
      if (arith) begin
        m_a  = src_a;
        m_b  = src_b;
        m_op = (ins[15:12] == 4'b0001) ? 3'b001 : 3'b000;
      end

      // Fetch cycle.
      @(negedge clk);
      check($sformatf("%s fetch[%0d]", name, k),
            64'({bus.ir_en, bus.reg_rd, bus.reg_wr, bus.pc}),
            64'({1'b1, 1'b0, 1'b0, m_pc}));

      n_rd = 0; n_wr = 0; n_fetch = 0; n_both = 0; wr_off = 0;
      rd_addrs = 4'd0; wa = 2'd0; wd = 8'd0;
      for (int c = 1; c < lat; c++) begin
        @(negedge clk);
        if (bus.ir_en) n_fetch++;
        if (bus.reg_rd && bus.reg_wr) n_both++;
        if (bus.reg_rd) begin
          n_rd++;
          rd_addrs = {rd_addrs[1:0], bus.reg_addr};
        end
        if (bus.reg_wr) begin
          n_wr++;
          wa = bus.reg_addr;
          wd = bus.reg_wdata;
          wr_off = c;
        end
      end

      check($sformatf("%s strobes[%0d]", name, k),
            64'({8'(n_fetch), 8'(n_both), 8'(n_wr)}),
            64'({8'd0, 8'd0, 8'(exp_wr)}));
      check($sformatf("%s reads[%0d]", name, k),
            64'({8'(n_rd), rd_addrs}),
            arith ? 64'({8'd2, ins[5:4], ins[1:0]}) : 64'({8'd0, 4'd0}));
      if (exp_wr)
        check($sformatf("%s write[%0d]", name, k),
              64'({wa, wd, 8'(wr_off)}),
              64'({exp_wa, exp_wd, 8'(lat - 1)}));
      check($sformatf("%s alu_regs[%0d]", name, k),
            64'({bus.alu_opcode, bus.alu_a, bus.alu_b}),
            64'({m_op, m_a, m_b}));

      if (exp_wr) m_r[exp_wa] = exp_wd;
      m_pc = next_pc;
    end
  endtask

  initial begin
    #2;

    // LOAD r1,5 then NOPs up to the program end.
    fill_prog(16'h5000);
    prog[0] = 16'h8105;
    init_r = '{8'd0, 8'd0, 8'd0, 8'd0};
    run_program("load", 50);
    check("load r1", 64'(rf[1]), 64'd5);

    // ADD r0 = r1 + r2 with r1 = 5, r2 = 3.
    fill_prog(16'h5000);
    prog[0] = 16'h8105;
    prog[1] = 16'h8203;
    prog[2] = 16'h0012;
    init_r = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_program("add", 50);
    check("add r0", 64'(rf[0]), 64'd8);

    // SUB r3 = r1 - r2 wrapping below zero.
    fill_prog(16'h5000);
    prog[0] = 16'h8103;
    prog[1] = 16'h8205;
    prog[2] = 16'h1312;
    run_program("sub", 50);
    check("sub r3", 64'(rf[3]), 64'hFE);

    // Endless JMP loop 1..3, stopped by the instruction cap.
    fill_prog(16'h5000);
    prog[3] = 16'hF001;
    run_program("jmp_loop", 10);

    // JMP outside the program halts on the following fetch.
    fill_prog(16'h5000);
    prog[0] = 16'hF020;
    run_program("jmp_out", 5);

    // Eleven NOPs run straight into the program end.
    fill_prog(16'h5000);
    run_program("nops", 50);

    // Random programs, operands overlapping rd included.
    for (int p = 0; p < 12; p++) begin
      fill_prog(16'h5000);
      for (int i = 0; i < PROG_LEN; i++) prog[i] = rand_inst();
      for (int i = 0; i < 4; i++) init_r[i] = 8'($urandom);
      run_program($sformatf("rand%0d", p), 40);
    end

    // Reset asserted during the EXEC cycle of an ADD.
    fill_prog(16'h5000);
    prog[0] = 16'h8105;
    prog[1] = 16'h8203;
    prog[2] = 16'h0012;
    init_r = '{8'h77, 8'd0, 8'd0, 8'd0};
    do_reset();
    repeat (11) @(negedge clk);
    check("mid_exec operands", 64'({bus.alu_opcode, bus.alu_a, bus.alu_b}),
          64'({3'b000, 8'd5, 8'd3}));
    #1 rst = 1'b1;
    #1 check("mid_exec async reset", out_vec(), 64'd0);
    @(posedge clk);
    #1 check("mid_exec reset held", out_vec(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("restart fetch", 64'({bus.ir_en, bus.reg_wr, bus.pc}),
          64'({1'b1, 1'b0, 8'd0}));
    check("abandoned write", 64'(rf[0]), 64'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
